write_back: RTL and testbench

//   Write-back (W) stage of the 5-stage RV32I pipeline. Selects the value that

---
 rtl/write_back.sv | 71 +++++++
 tb/tb_write_back.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// ============================================================================
// Module   : write_back
// Purpose  : RV32I write-back stage result mux (ALU / load data / PC+4 link).
//            Optional macro WB_RESULT_REG_EN registers the result (1 cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module write_back #(
    parameter int XLEN             = 32,
    parameter int RESULT_SRC_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcW,
    input  logic [XLEN-1:0]             PCPlus4W,
    input  logic [XLEN-1:0]             ALUResultW,
    input  logic [XLEN-1:0]             ReadDataW,
    output logic [XLEN-1:0]             ResultW
);

    logic [XLEN-1:0] result_d;

    generate
        if (RESULT_SRC_WIDTH == 1) begin : g_sel1
            // The link value is not a candidate in this configuration.
            logic w_unused_pc;
            assign w_unused_pc = ^PCPlus4W;
            assign result_d    = ResultSrcW[0] ? ReadDataW : ALUResultW;
        end else if (RESULT_SRC_WIDTH == 2) begin : g_sel2
            localparam logic [1:0] c_SEL_ALU  = 2'b00;
            localparam logic [1:0] c_SEL_LOAD = 2'b01;
            localparam logic [1:0] c_SEL_LINK = 2'b10;

            always_comb begin
                result_d = ALUResultW;
                case (ResultSrcW)
                    c_SEL_ALU:  result_d = ALUResultW;
                    c_SEL_LOAD: result_d = ReadDataW;
                    c_SEL_LINK: result_d = PCPlus4W;
                    default:    result_d = ALUResultW; // reserved encoding
                endcase
            end
        end else begin : g_bad_cfg
            $error("write_back: RESULT_SRC_WIDTH must be 1 or 2");
            assign result_d = '0;
        end
    endgenerate

`ifdef WB_RESULT_REG_EN
    logic [XLEN-1:0] result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign ResultW = result_q;
`else
    // Purely combinational build: clock and reset are intentionally unused.
    logic w_unused_clkrst;
    assign w_unused_clkrst = clk ^ rst;
    assign ResultW         = result_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_write_back.sv
// ============================================================================
// Module   : tb_write_back
// Purpose  : Directed self-checking bench for write_back (both select widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_back;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel1;
    logic [1:0]  sel2;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] res1;
    logic [31:0] res2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_back #(.XLEN(32), .RESULT_SRC_WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .ResultSrcW (sel1),
        .PCPlus4W   (pc),
        .ALUResultW (alu),
        .ReadDataW  (rd),
        .ResultW    (res1)
    );

    write_back #(.XLEN(32), .RESULT_SRC_WIDTH(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .ResultSrcW (sel2),
        .PCPlus4W   (pc),
        .ALUResultW (alu),
        .ReadDataW  (rd),
        .ResultW    (res2)
    );

    // Let a new input take effect: immediate in the combinational build,
    // one rising edge in the registered build.
    task automatic settle;
`ifdef WB_RESULT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset;
        logic [31:0] exp_v;
        rst  = 1'b1;
        sel1 = 1'b0;
        sel2 = 2'b00;
        pc   = 32'h0000_0004;
        alu  = 32'h0000_0008;
        rd   = 32'h0000_000C;
        #1;
`ifdef WB_RESULT_REG_EN
        exp_v = 32'h0;
`else
        exp_v = 32'h0000_0008;
`endif
        checks++;
        if (res1 !== exp_v) begin
            errors++;
            $display("FAIL reset_w1: got %h expected %h", res1, exp_v);
        end
        checks++;
        if (res2 !== exp_v) begin
            errors++;
            $display("FAIL reset_w2: got %h expected %h", res2, exp_v);
        end
        // Reset must hold through a clock edge.
        @(posedge clk);
        #1;
        checks++;
        if (res1 !== exp_v) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", res1, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (res1 !== exp_v) begin
            errors++;
            $display("FAIL reset_release_pre_edge: got %h expected %h", res1, exp_v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res1 !== 32'h0000_0008) begin
            errors++;
            $display("FAIL reset_release_post_edge: got %h expected %h", res1, 32'h0000_0008);
        end
    endtask

    task automatic test_select_w1;
        sel1 = 1'b0;
        settle();
        checks++;
        if (res1 !== 32'h0000_0008) begin
            errors++;
            $display("FAIL w1_sel0: got %h expected %h", res1, 32'h0000_0008);
        end
        sel1 = 1'b1;
        settle();
        checks++;
        if (res1 !== 32'h0000_000C) begin
            errors++;
            $display("FAIL w1_sel1: got %h expected %h", res1, 32'h0000_000C);
        end
        // PC+4 must not leak into the 1-bit-select variant.
        pc = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (res1 !== 32'h0000_000C) begin
            errors++;
            $display("FAIL w1_pc_ignored: got %h expected %h", res1, 32'h0000_000C);
        end
        pc = 32'h0000_0004;
    endtask

    task automatic test_clk_independence;
        logic [31:0] exp_v;
        @(negedge clk);
        sel1 = 1'b0;
        #1;
`ifdef WB_RESULT_REG_EN
        exp_v = 32'h0000_000C;
`else
        exp_v = 32'h0000_0008;
`endif
        checks++;
        if (res1 !== exp_v) begin
            errors++;
            $display("FAIL sel_between_edges: got %h expected %h", res1, exp_v);
        end
        sel1 = 1'b1;
        #1;
        checks++;
        if (res1 !== 32'h0000_000C) begin
            errors++;
            $display("FAIL sel_back_between_edges: got %h expected %h", res1, 32'h0000_000C);
        end
        sel1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (res1 !== 32'h0000_0008) begin
            errors++;
            $display("FAIL sel_after_edge: got %h expected %h", res1, 32'h0000_0008);
        end
    endtask

    task automatic test_select_w2;
        logic [31:0] exp_t [4];
        exp_t = '{32'h0000_0008, 32'h0000_000C, 32'h0000_0004, 32'h0000_0008};
        for (int i = 0; i < 4; i++) begin
            sel2 = 2'(i);
            settle();
            checks++;
            if (res2 !== exp_t[i]) begin
                errors++;
                $display("FAIL w2_sel%0d: got %h expected %h", i, res2, exp_t[i]);
            end
        end
    endtask

    task automatic test_boundary;
        logic [1:0]  s2_t  [3];
        logic [31:0] e2_t  [3];
        alu  = 32'hFFFF_FFFF;
        rd   = 32'h8000_0000;
        pc   = 32'h0000_0001;
        sel1 = 1'b0;
        settle();
        checks++;
        if (res1 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL bnd_w1_alu: got %h expected %h", res1, 32'hFFFF_FFFF);
        end
        sel1 = 1'b1;
        settle();
        checks++;
        if (res1 !== 32'h8000_0000) begin
            errors++;
            $display("FAIL bnd_w1_load: got %h expected %h", res1, 32'h8000_0000);
        end
        s2_t = '{2'b11, 2'b01, 2'b10};
        e2_t = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        for (int i = 0; i < 3; i++) begin
            sel2 = s2_t[i];
            settle();
            checks++;
            if (res2 !== e2_t[i]) begin
                errors++;
                $display("FAIL bnd_w2_sel%0d: got %h expected %h", s2_t[i], res2, e2_t[i]);
            end
        end
    endtask

`ifdef WB_RESULT_REG_EN
    task automatic test_mid_reset;
        alu  = 32'h0000_0008;
        rd   = 32'h0000_000C;
        sel1 = 1'b1;
        settle();
        checks++;
        if (res1 !== 32'h0000_000C) begin
            errors++;
            $display("FAIL midrst_pre: got %h expected %h", res1, 32'h0000_000C);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (res1 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async: got %h expected %h", res1, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res1 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_hold: got %h expected %h", res1, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (res1 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_release: got %h expected %h", res1, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res1 !== 32'h0000_000C) begin
            errors++;
            $display("FAIL midrst_reload: got %h expected %h", res1, 32'h0000_000C);
        end
    endtask
`endif

    task automatic test_back_to_back;
        logic [31:0] a_t  [4];
        logic [31:0] r_t  [4];
        logic [31:0] p_t  [4];
        logic        s1_t [4];
        logic [1:0]  s2_t [4];
        logic [31:0] e1_t [4];
        logic [31:0] e2_t [4];
        a_t  = '{32'h1234_5678, 32'h0000_0000, 32'hA5A5_A5A5, 32'h7FFF_FFFF};
        r_t  = '{32'h9ABC_DEF0, 32'hFFFF_0000, 32'h5A5A_5A5A, 32'h0000_0001};
        p_t  = '{32'h0000_1004, 32'h0000_2008, 32'h8000_0004, 32'h0000_0010};
        s1_t = '{1'b1, 1'b0, 1'b1, 1'b0};
        s2_t = '{2'b10, 2'b01, 2'b00, 2'b11};
        e1_t = '{32'h9ABC_DEF0, 32'h0000_0000, 32'h5A5A_5A5A, 32'h7FFF_FFFF};
        e2_t = '{32'h0000_1004, 32'hFFFF_0000, 32'hA5A5_A5A5, 32'h7FFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            alu  = a_t[i];
            rd   = r_t[i];
            pc   = p_t[i];
            sel1 = s1_t[i];
            sel2 = s2_t[i];
            settle();
            checks++;
            if (res1 !== e1_t[i]) begin
                errors++;
                $display("FAIL b2b_w1_%0d: got %h expected %h", i, res1, e1_t[i]);
            end
            checks++;
            if (res2 !== e2_t[i]) begin
                errors++;
                $display("FAIL b2b_w2_%0d: got %h expected %h", i, res2, e2_t[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_select_w1();
        test_clk_independence();
        test_select_w2();
        test_boundary();
`ifdef WB_RESULT_REG_EN
        test_mid_reset();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
